// File: rtl/measurement_sequencer_pkg.sv
// measurement_sequencer_pkg: state encoding, parameter legal ranges and timer sizing shared by the sequencer
package measurement_sequencer_pkg;
  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, CONVERT, DONE} state_t;
  localparam int MIN_SETTLE_CYCLES = 1;
  localparam int MIN_CONV_TIMEOUT = 1;
  localparam int MAX_LOG2_SAMPLES = 4;
  function automatic int timer_width(input int a, input int b);
    return $clog2((a > b ? a : b) + 1);
  endfunction
endpackage

// File: rtl/sequencer_timer.sv
// sequencer_timer: loadable saturating down-counter; ports clk, rst_n, load, value in, zero out (count==0)
module sequencer_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             zero
);
  logic [WIDTH-1:0] count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else count <= load ? value : (count == '0 ? count : count - 1'b1);
  assign zero = count == '0;
endmodule

// File: rtl/measurement_sequencer.sv
// measurement_sequencer: settle/sample/convert/average sequencer; ins clk rst_n start abort cfg adc_*; outs busy result* timeout_err sens_*/adc_* controls
module measurement_sequencer
  import measurement_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = 64,
  parameter int CONV_TIMEOUT  = 1024,
  parameter int LOG2_SAMPLES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [2:0]  cfg,
  input  logic        adc_conversion_complete,
  input  logic [15:0] adc_value,
  output logic        busy,
  output logic        result_valid,
  output logic [15:0] result,
  output logic        timeout_err,
  output logic [2:0]  sens_config,
  output logic        sens_enable,
  output logic        sens_read,
  output logic        adc_enable,
  output logic        adc_read
);
  localparam int TW = timer_width(SETTLE_CYCLES, CONV_TIMEOUT);
  localparam int AW = 16 + LOG2_SAMPLES;
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] CONV_LOAD = TW'(CONV_TIMEOUT - 1);
  localparam logic [LOG2_SAMPLES:0] LAST = (LOG2_SAMPLES + 1)'((1 << LOG2_SAMPLES) - 1);
  if (SETTLE_CYCLES < MIN_SETTLE_CYCLES) begin : g_bad_settle
    $error("SETTLE_CYCLES must be >= 1");
  end
  if (CONV_TIMEOUT < MIN_CONV_TIMEOUT) begin : g_bad_timeout
    $error("CONV_TIMEOUT must be >= 1");
  end
  if (LOG2_SAMPLES < 0 || LOG2_SAMPLES > MAX_LOG2_SAMPLES) begin : g_bad_log2
    $error("LOG2_SAMPLES must be in 0..4");
  end
  state_t state;
  logic [AW-1:0] acc;
  logic [AW-1:0] sum;
  logic [LOG2_SAMPLES:0] cnt;
  logic accept;
  logic load;
  logic [TW-1:0] load_value;
  logic timer_zero;
  assign accept = state == IDLE && start && !abort;
  assign load = accept || state == SAMPLE;
  assign load_value = state == SAMPLE ? CONV_LOAD : SETTLE_LOAD;
  assign sum = acc + AW'(adc_value);
  sequencer_timer #(.WIDTH(TW)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .value(load_value),
    .zero (timer_zero)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      busy <= 1'b0;
      result_valid <= 1'b0;
      result <= 16'h0000;
      timeout_err <= 1'b0;
      sens_config <= 3'b000;
      sens_enable <= 1'b0;
      sens_read <= 1'b0;
      adc_enable <= 1'b0;
      adc_read <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      sens_read <= 1'b0;
      adc_read <= 1'b0;
      if (abort && state != IDLE) begin
        state <= IDLE;
        busy <= 1'b0;
        sens_enable <= 1'b0;
        adc_enable <= 1'b0;
      end else begin
        case (state)
          IDLE:
            if (accept) begin
              state <= SETTLE;
              sens_config <= cfg;
              sens_enable <= 1'b1;
              adc_enable <= 1'b1;
              busy <= 1'b1;
              timeout_err <= 1'b0;
              acc <= '0;
              cnt <= '0;
            end
          SETTLE:
            if (timer_zero) begin
              state <= SAMPLE;
              sens_read <= 1'b1;
              adc_read <= 1'b1;
            end
          SAMPLE: state <= CONVERT;
          CONVERT:
            if (adc_conversion_complete) begin
              acc <= sum;
              cnt <= cnt + 1'b1;
              if (cnt == LAST) begin
                state <= DONE;
                result <= 16'(sum >> LOG2_SAMPLES);
                result_valid <= 1'b1;
              end else begin
                state <= SAMPLE;
                sens_read <= 1'b1;
                adc_read <= 1'b1;
              end
            end else if (timer_zero) begin
              state <= IDLE;
              timeout_err <= 1'b1;
              busy <= 1'b0;
              sens_enable <= 1'b0;
              adc_enable <= 1'b0;
            end
          DONE: begin
            state <= IDLE;
            busy <= 1'b0;
            sens_enable <= 1'b0;
            adc_enable <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
endmodule

// File: doc/measurement_sequencer.md
MEASUREMENT_SEQUENCER -- requirements
Module: measurement_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 64, sensor settle time after enable in clk cycles; legal range >=1, elaboration error otherwise.
REQ-002 SHALL have parameter CONV_TIMEOUT, default 1024, max clk cycles to wait for adc_conversion_complete; legal range >=1.
REQ-003 SHALL have parameter LOG2_SAMPLES, default 2, log2 of conversions averaged per measurement; legal range 0..4.
REQ-004 clk  in  1  13.56MHz recovered carrier clock; sole clock.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 start  in  1  one-cycle request for one measurement.
REQ-007 abort  in  1  one-cycle request to cancel any measurement in progress.
REQ-008 cfg  in  3  sensor configuration, sampled on an accepted start.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 result_valid  out  1  one-cycle pulse when result is updated.
REQ-011 result  out  16  averaged ADC value; holds between updates.
REQ-012 timeout_err  out  1  sticky conversion-timeout flag.
REQ-013 sens_config  out  3;  sens_enable, sens_read, adc_enable, adc_read  out  1 each  sensor/ADC controls.
REQ-014 adc_conversion_complete  in  1;  adc_value  in  16  ADC status and data, already synchronous to clk.

Function
REQ-015 States SHALL be IDLE, SETTLE, SAMPLE, CONVERT, DONE; all outputs registered.
REQ-016 IDLE: start=1 and abort=0 -> SETTLE next cycle; sens_config<=cfg, sens_enable=adc_enable=1, busy=1, timeout_err<=0, accumulator and sample count <=0.
REQ-017 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then -> SAMPLE.
REQ-018 SAMPLE SHALL last exactly 1 cycle with sens_read=adc_read=1, then -> CONVERT; sens_read/adc_read are 0 in every other state.
REQ-019 CONVERT: adc_conversion_complete=1 -> accumulator += adc_value (width 16+LOG2_SAMPLES, no overflow), count+1; if count reaches 2^LOG2_SAMPLES -> DONE, else -> SAMPLE (no re-settle).
REQ-020 CONVERT: no complete within CONV_TIMEOUT cycles (cycle CONVERT entered = cycle 1) -> IDLE, timeout_err=1, no result_valid, enables drop to 0.
REQ-021 adc_conversion_complete outside CONVERT SHALL be ignored.
REQ-022 DONE (1 cycle): result <= accumulator >> LOG2_SAMPLES (truncating), result_valid=1, -> IDLE; sens_enable/adc_enable 0 from the cycle after DONE.
REQ-023 start outside IDLE SHALL be ignored, including in DONE.
REQ-024 abort in any non-IDLE state -> IDLE next cycle; enables 0, no result_valid, result and timeout_err unchanged.
REQ-025 abort wins over simultaneous start, complete, or timeout expiry.
REQ-026 sens_config SHALL hold its last value in IDLE.

Reset
REQ-027 rst_n low SHALL force IDLE immediately; all outputs 0, result=16'h0000, accumulator, counters and timeout_err cleared.
REQ-028 Reset mid-measurement SHALL discard it with no result_valid after release.

Structure
REQ-029 State enum and parameter legal-range constants SHALL live in package measurement_sequencer_pkg.
REQ-030 A loadable down-counter sub-module, sequencer_timer, SHALL be shared between SETTLE and CONVERT timing.

Verification
REQ-031 Defaults, start, cfg=3'b101, completes after 10 cycles with values 100,101,102,103 -> sens_config=5, result=101, one result_valid, busy low after DONE.
REQ-032 SETTLE_CYCLES=4: first sens_read exactly 4 cycles after SETTLE entry; sens_read and adc_read each 1 cycle wide per sample.
REQ-033 CONV_TIMEOUT=8, complete never asserted -> IDLE after 8 CONVERT cycles, timeout_err=1, no result_valid; next start clears timeout_err.
REQ-034 abort in same cycle as the 4th complete -> IDLE, no result_valid, result keeps previous value.
REQ-035 start while busy and complete pulse in SETTLE -> both ignored, accumulated result unaffected.
REQ-036 rst_n low during CONVERT, then released -> all outputs 0, busy=0, no result_valid.
